// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and widths for the mux scan sequencer
package mux_scan_pkg;
  localparam int DATA_W = 16;
  localparam int SEL_W = 4;
  localparam int CNT_MAX = 255;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that parks at zero
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  output logic zero
);
  cnt_t cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - cnt_t'(1);
  assign zero = cnt_q == '0;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 16:1 mux select, samples its output and checks it against the sent word
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  data_t din,
  output data_t mux_in,
  output sel_t mux_sl,
  input  logic mux_out,
  output logic busy,
  output logic sout,
  output logic sout_valid,
  output data_t result,
  output logic done,
  output logic mismatch
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_MAX) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  localparam sel_t FIRST = LSB_FIRST ? sel_t'(0) : sel_t'(DATA_W - 1);
  localparam sel_t LAST = LSB_FIRST ? sel_t'(DATA_W - 1) : sel_t'(0);
  localparam cnt_t RELOAD = cnt_t'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  data_t mux_in_q, mux_in_d, result_q, result_d;
  sel_t sl_q, sl_d;
  logic sout_q, sout_d, sout_valid_q, mismatch_q, mismatch_d, load, zero;
  settle_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(RELOAD),
    .zero(zero)
  );
  always_comb begin
    state_d = state_q;
    mux_in_d = mux_in_q;
    sl_d = sl_q;
    result_d = result_q;
    sout_d = sout_q;
    mismatch_d = mismatch_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mux_in_d = din;
        sl_d = FIRST;
        result_d = '0;
        mismatch_d = 1'b0;
        load = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: state_d = zero ? SAMPLE : SETTLE;
      SAMPLE: begin
        sout_d = mux_out;
        result_d[sl_q] = mux_out;
        load = sl_q != LAST;
        sl_d = sl_q == LAST ? sl_q : LSB_FIRST ? sl_q + sel_t'(1) : sl_q - sel_t'(1);
        state_d = sl_q == LAST ? DONE : SETTLE;
      end
      DONE: begin
        mismatch_d = result_q != mux_in_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      mux_in_q <= '0;
      sl_q <= '0;
      result_q <= '0;
      sout_q <= 1'b0;
      sout_valid_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mux_in_q <= mux_in_d;
      sl_q <= sl_d;
      result_q <= result_d;
      sout_q <= sout_d;
      sout_valid_q <= state_q == SAMPLE;
      mismatch_q <= mismatch_d;
    end
  assign mux_in = mux_in_q;
  assign mux_sl = sl_q;
  assign result = result_q;
  assign sout = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy = state_q == SETTLE || state_q == SAMPLE;
  assign done = state_q == DONE;
  // the DONE-cycle compare is visible immediately, then held in mismatch_q
  assign mismatch = mismatch_q | (done & (result_q != mux_in_q));
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed checks of two sequencer configurations against behavioural muxes
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst, start, start2, stuck;
  logic [15:0] din, din2, mux_in, mux_in2, result, result2, sb, sb2;
  logic [3:0] mux_sl, mux_sl2, sl1, sl2, sl3;
  logic mux_out, mux_out2, busy, busy2, sout, sout2, sv, sv2, done, done2, mm, mm2;
  int errors = 0, total = 0, nv = 0, nv2 = 0, nd = 0, cyc = 0;
  logic anyout;

  always #5 clk = ~clk;

  mux_scan_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .mux_in(mux_in), .mux_sl(mux_sl),
    .mux_out(mux_out), .busy(busy), .sout(sout), .sout_valid(sv), .result(result),
    .done(done), .mismatch(mm)
  );
  mux_scan_sequencer #(.SETTLE_CYCLES(1), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din(din2), .mux_in(mux_in2), .mux_sl(mux_sl2),
    .mux_out(mux_out2), .busy(busy2), .sout(sout2), .sout_valid(sv2), .result(result2),
    .done(done2), .mismatch(mm2)
  );

  always @(posedge clk) begin
    sl1 <= mux_sl;
    sl2 <= sl1;
    sl3 <= sl2;
  end
  assign mux_out = (stuck && sl3 == 4'd7) ? 1'b0 : mux_in[sl3];
  assign mux_out2 = mux_in2[mux_sl2];

  always @(posedge clk) begin
    #1;
    if (sv) begin nv++; sb = {sb[14:0], sout}; end
    if (sv2) begin nv2++; sb2 = {sb2[14:0], sout2}; end
    if (done) nd++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
      c++;
    end while (!(done || done2) && c < 400);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; stuck = 1'b0; din = '0; din2 = '0;
    sb = '0; sb2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {mux_in, mux_sl, result, sout, sv, busy, done, mm}, 64'd0);
    anyout = 1'b0;
    repeat (20) begin
      @(negedge clk);
      anyout |= {mux_in, mux_sl, result, sout, sv, busy, done, mm} != '0;
    end
    chk("idle_outputs", anyout, 0);
    chk("idle_no_valid", nv, 0);

    nv = 0; sb = '0; din = 16'hA5C3; start = 1'b1;
    wait_done(cyc);
    chk("loop_latency", cyc, 81);
    chk("loop_result", result, 16'hA5C3);
    chk("loop_mismatch", mm, 0);
    chk("loop_busy_in_done", busy, 0);
    chk("loop_last_sl", mux_sl, 4'd15);
    chk("loop_nvalid", nv, 16);
    chk("loop_sout_seq", sb, 16'hC3A5);
    @(negedge clk);
    chk("loop_done_pulse", done, 0);

    stuck = 1'b1; din = 16'hFFFF; start = 1'b1;
    wait_done(cyc);
    chk("stuck_latency", cyc, 81);
    chk("stuck_result", result, 16'hFF7F);
    chk("stuck_mismatch_done", mm, 1);
    @(negedge clk);
    chk("stuck_mismatch_sticky", mm, 1);
    stuck = 1'b0;

    nd = 0; din = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mismatch_cleared", mm, 0);
    repeat (9) @(negedge clk);
    din = 16'hFFFF; start = 1'b1;
    wait_done(cyc);
    chk("busy_result", result, 16'h0001);
    chk("busy_mux_in", mux_in, 16'h0001);
    repeat (100) @(negedge clk);
    chk("busy_one_done", nd, 1);
    chk("busy_idle_after", busy, 0);

    nd = 0; din = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", {busy, done, mm, mux_sl, mux_in, result}, 64'd0);
    repeat (90) @(negedge clk);
    chk("midrst_no_done", nd, 0);
    din = 16'h5A5A; start = 1'b1;
    wait_done(cyc);
    chk("midrst_restart_latency", cyc, 81);
    chk("midrst_restart_result", result, 16'h5A5A);

    nv2 = 0; sb2 = '0; din2 = 16'h8000; start2 = 1'b1;
    wait_done(cyc);
    chk("msb_latency", cyc, 33);
    chk("msb_result", result2, 16'h8000);
    chk("msb_mismatch", mm2, 0);
    chk("msb_last_sl", mux_sl2, 4'd0);
    chk("msb_nvalid", nv2, 16);
    chk("msb_sout_seq", sb2, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
